// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte-transmitter state encoding and bus constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Value presented on sda_out whenever the line is not actively driven.
  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_byte_transmitter.sv
// I2C byte serializer: shifts a byte MSB-first on SCL-low phases, then opens the ACK slot.
// Latency: first bit on SDA 1 CLK after accept; result pulse 1 CLK after the slot-closing event.
// Backpressure: tx_ready only in IDLE; abort returns to IDLE and drops the byte.
module i2c_byte_transmitter #(
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              scl_fall,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              abort,
  input  logic              ack_in,
  input  logic              nack_in,
  output logic              sda_out,
  output logic              sda_oe,
  output logic              wait_ack,
  output logic              busy,
  output logic              byte_done,
  output logic              ack_ok,
  output logic              nack,
  output logic              timeout
);
  import i2c_pkg::*;

  localparam int BW = $clog2(DATA_W);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t            state_q,     state_nxt;
  logic [DATA_W-1:0] shreg_q,     shreg_nxt;
  logic [BW-1:0]     bit_cnt_q,   bit_cnt_nxt;
  logic [TW-1:0]     tmo_cnt_q,   tmo_cnt_nxt;
  logic              ack_ok_q,    ack_ok_nxt;
  logic              nack_q,      nack_nxt;
  logic              byte_done_q, byte_done_nxt;
  logic              timeout_q,   timeout_nxt;
  logic              slot_ack;

  // Registers all state; reset drives the bus-facing outputs to released at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      ack_ok_q    <= 1'b0;
      nack_q      <= 1'b0;
      byte_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      shreg_q     <= shreg_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      tmo_cnt_q   <= tmo_cnt_nxt;
      ack_ok_q    <= ack_ok_nxt;
      nack_q      <= nack_nxt;
      byte_done_q <= byte_done_nxt;
      timeout_q   <= timeout_nxt;
    end
  end

  // A simultaneous ack_in/nack_in is illegal and resolves to NACK.
  assign slot_ack = ack_in & ~nack_in;

  // Next-state and datapath: abort has top priority, then the SCL edge, then the timeout.
  always_comb begin
    state_nxt     = state_q;
    shreg_nxt     = shreg_q;
    bit_cnt_nxt   = bit_cnt_q;
    tmo_cnt_nxt   = tmo_cnt_q;
    ack_ok_nxt    = ack_ok_q;
    nack_nxt      = nack_q;
    byte_done_nxt = 1'b0;
    timeout_nxt   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            state_nxt   = SHIFT;
            shreg_nxt   = tx_data;
            bit_cnt_nxt = '0;
            ack_ok_nxt  = 1'b0;
            nack_nxt    = 1'b0;
          end
        end
        SHIFT: begin
          if (scl_fall) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_nxt   = ACK;
              tmo_cnt_nxt = '0;
            end else begin
              shreg_nxt   = {shreg_q[DATA_W-2:0], 1'b0};
              bit_cnt_nxt = bit_cnt_q + BW'(1);
            end
          end
        end
        ACK: begin
          if (scl_fall) begin
            state_nxt     = IDLE;
            ack_ok_nxt    = slot_ack;
            nack_nxt      = ~slot_ack;
            byte_done_nxt = 1'b1;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_nxt     = IDLE;
            ack_ok_nxt    = 1'b0;
            nack_nxt      = 1'b1;
            byte_done_nxt = 1'b1;
            timeout_nxt   = 1'b1;
          end else begin
            tmo_cnt_nxt = tmo_cnt_q + TW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sda_oe    = (state_q == SHIFT);
  assign sda_out   = sda_oe ? shreg_q[DATA_W-1] : SDA_RELEASE;
  assign wait_ack  = (state_q == ACK);
  assign byte_done = byte_done_q;
  assign ack_ok    = ack_ok_q;
  assign nack      = nack_q;
  assign timeout   = timeout_q;

endmodule
